// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, datapath
// widths and the default data-memory depth.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam int DATA_W            = 8;
  localparam int ADDR_W            = 8;
  localparam int CNT_W             = 8;
  localparam int DEFAULT_MEM_DEPTH = 32;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit counter that sticks at 255 instead of wrapping; used for debug counts.
module sat_counter8
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer in front of a registered data memory,
// with address range checking and saturating debug counters.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_DEPTH    = DEFAULT_MEM_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  fault_count
);

  // One extra bit so a depth of 256 still compares correctly against 8-bit addresses.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [1:0]      LP_LAT   = 2'(READ_LATENCY);

  lsu_state_e        r_state;
  logic              r_store;
  logic [1:0]        r_lat_cnt;
  logic              r_resp_valid;
  logic              r_resp_fault;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_handshake;
  logic w_addr_fault;

  assign req_ready    = (r_state == ST_IDLE) && !rst;
  assign w_addr_fault = ({1'b0, req_addr} >= LP_DEPTH);
  assign w_handshake  = (r_state == ST_RESP) && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_store      <= 1'b0;
      r_lat_cnt    <= 2'd0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_data  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            if (w_addr_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_data  <= '0;
            end else begin
              r_state     <= ST_ISSUE;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= req_wdata;
              // Write enable is registered so it is high for exactly the ISSUE cycle.
              r_mem_we    <= req_store;
            end
          end
        end
        ST_ISSUE: begin
          r_mem_we <= 1'b0;
          if (r_store) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
          end else begin
            r_state   <= ST_WAIT;
            r_lat_cnt <= LP_LAT;
          end
        end
        ST_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 2'd1;
          if (r_lat_cnt == 2'd1) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_data  <= mem_rdata;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_data  = r_resp_data;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  // A faulted request counts only as a fault, never as a load or store.
  sat_counter8 u_load_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_handshake && !r_resp_fault && !r_store),
    .o_count (load_count)
  );

  sat_counter8 u_store_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_handshake && !r_resp_fault && r_store),
    .o_count (store_count)
  );

  sat_counter8 u_fault_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_handshake && r_resp_fault),
    .o_count (fault_count)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued at issue
// and popped by an independent monitor at each response handshake.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_store;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_ready, resp_fault;
  logic [7:0] resp_data;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] load_count, store_count, fault_count;

  typedef struct packed {
    logic [7:0] data;
    logic       fault;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(32), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
  );

  // Registered data memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", {24'd0, resp_data}, {24'd0, e.data});
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
      end
    end
  end

  // Called at posedge+1 with the unit idle; returns once the response has been taken.
  task automatic do_req(input logic st, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_data, input logic exp_fault,
                        input int exp_lat, input bit verbose);
    int lat, we_cnt, guard;
    exp_t e;
    if (verbose) chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    e.data = exp_data; e.fault = exp_fault;
    q.push_back(e);
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; we_cnt = 0;
    while (1) begin
      if (mem_we) begin
        we_cnt++;
        if (verbose) begin
          chk("mem_addr", {24'd0, mem_addr}, {24'd0, a});
          chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
        end
      end
      if (resp_valid || lat > 20) break;
      @(posedge clk); #1;
      lat++;
    end
    if (verbose) begin
      chk("resp_latency", lat, exp_lat);
      chk("mem_we_cycles", we_cnt, (st && !exp_fault) ? 1 : 0);
    end
    guard = 0;
    while (resp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) chk("resp_drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_counts", {8'd0, load_count, store_count, fault_count}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b1, 8'd5,   8'hA5, 8'h00, 1'b0, 2, 1'b1);
    chk("store_count_1", {24'd0, store_count}, 32'd1);
    do_req(1'b0, 8'd5,   8'h00, 8'hA5, 1'b0, 3, 1'b1);
    chk("load_count_1", {24'd0, load_count}, 32'd1);
    do_req(1'b0, 8'd32,  8'h00, 8'h00, 1'b1, 1, 1'b1);
    do_req(1'b0, 8'hFF,  8'h00, 8'h00, 1'b1, 1, 1'b1);
    do_req(1'b1, 8'd40,  8'h11, 8'h00, 1'b1, 1, 1'b1);
    chk("fault_count_3", {24'd0, fault_count}, 32'd3);
    do_req(1'b1, 8'd31,  8'h3C, 8'h00, 1'b0, 2, 1'b1);
    do_req(1'b0, 8'd31,  8'h00, 8'h3C, 1'b0, 3, 1'b1);

    // Back-pressure: response held for 4 cycles while another request waits.
    resp_ready = 1'b0;
    q.push_back('{data: 8'hA5, fault: 1'b0});
    req_valid = 1'b1; req_store = 1'b0; req_addr = 8'd5; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_store = 1'b1; req_addr = 8'd6; req_wdata = 8'h77;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("hold_resp_seen", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_resp_data", {24'd0, resp_data}, 32'hA5);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_mem_we", {31'd0, mem_we}, 32'd0);
    end
    q.push_back('{data: 8'h00, fault: 1'b0});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_gap_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_gap_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_accept_ready", {31'd0, req_ready}, 32'd0);
    chk("second_mem_we", {31'd0, mem_we}, 32'd1);
    chk("second_mem_addr", {24'd0, mem_addr}, 32'd6);
    guard = 0;
    while (!resp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    chk("counts_before_rst", {8'd0, load_count, store_count, fault_count}, {8'd0, 8'd3, 8'd3, 8'd3});
    chk("mem6_written", {24'd0, mem[6]}, 32'h77);

    // Asynchronous reset in the ISSUE cycle of a store.
    req_valid = 1'b1; req_store = 1'b1; req_addr = 8'd7; req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_mem_we", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_mem_we", {31'd0, mem_we}, 32'd0);
    chk("async_req_ready", {31'd0, req_ready}, 32'd0);
    chk("async_outputs", {13'd0, resp_valid, resp_fault, resp_data, mem_addr, mem_wdata[0]}, 32'd0);
    chk("async_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("async_counts", {8'd0, load_count, store_count, fault_count}, 32'd0);
    q.delete();
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Store counter saturation.
    for (int i = 0; i < 254; i++) do_req(1'b1, 8'(i % 32), 8'(i), 8'h00, 1'b0, 2, 1'b0);
    chk("store_count_254", {24'd0, store_count}, 32'd254);
    do_req(1'b1, 8'd1, 8'h01, 8'h00, 1'b0, 2, 1'b0);
    chk("store_count_255", {24'd0, store_count}, 32'd255);
    for (int i = 0; i < 5; i++) do_req(1'b1, 8'd2, 8'h02, 8'h00, 1'b0, 2, 1'b0);
    chk("store_count_sat", {24'd0, store_count}, 32'd255);
    chk("load_count_after_sat", {24'd0, load_count}, 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
